// File: rtl/mfp_uart_transmitter.sv
// mfp_uart_transmitter: buffered 8N1 UART transmitter.
// Bytes queue in a circular FIFO and are shifted out LSB first on tx.
`timescale 1ns/1ps

module mfp_uart_transmitter #(
    parameter int CLOCK_FREQUENCY = 50000000,
    parameter int BAUD_RATE       = 115200,
    parameter int FIFO_DEPTH_LOG2 = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [7:0]               byte_data,
    input  logic                     byte_valid,
    output logic                     byte_ready,
    output logic                     tx,
    output logic                     busy,
    output logic [FIFO_DEPTH_LOG2:0] fifo_count
);

    localparam int CLKS_PER_BIT = CLOCK_FREQUENCY / BAUD_RATE;
    localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int AW = FIFO_DEPTH_LOG2;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

    if (CLKS_PER_BIT < 2) begin : g_bad_baud
        $error("mfp_uart_transmitter: CLOCK_FREQUENCY/BAUD_RATE must be >= 2");
    end

    if (FIFO_DEPTH_LOG2 < 1) begin : g_bad_depth
        $error("mfp_uart_transmitter: FIFO_DEPTH_LOG2 must be >= 1");
    end

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t           state;
    state_t           state_n;
    logic [CNT_W-1:0] baud_cnt;
    logic [CNT_W-1:0] baud_cnt_n;
    logic [2:0]       bit_idx;
    logic [2:0]       bit_idx_n;
    logic [7:0]       shift;
    logic [7:0]       shift_n;
    logic             tx_n;

    logic [7:0]    mem [0:(1<<AW)-1];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count_n;
    logic          push;
    logic          pop;
    logic          has_data;
    logic          baud_last;

    assign push      = byte_valid && byte_ready;
    assign has_data  = (fifo_count != '0);
    assign baud_last = (baud_cnt == CNT_LAST);
    assign busy      = (state != IDLE) || has_data;

    // FIFO storage; contents need no reset since the pointers gate them
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= byte_data;
        end
    end

    // Occupancy after this edge's push and pop
    always_comb begin
        count_n = fifo_count;
        case ({push, pop})
            2'b10:   count_n = fifo_count + 1'b1;
            2'b01:   count_n = fifo_count - 1'b1;
            default: count_n = fifo_count;
        endcase
    end

    // Pointers, count and a registered ready that never sees the pop combinationally
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            byte_ready <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            fifo_count <= count_n;
            byte_ready <= (count_n != DEPTH);
        end
    end

    // Framing FSM: next state, baud/bit counters, shifter and pop request
    always_comb begin
        state_n    = state;
        baud_cnt_n = baud_cnt + 1'b1;
        bit_idx_n  = bit_idx;
        shift_n    = shift;
        pop        = 1'b0;
        unique case (state)
            IDLE: begin
                baud_cnt_n = '0;
                if (has_data) begin
                    pop     = 1'b1;
                    state_n = START;
                end
            end
            START: begin
                if (baud_last) begin
                    baud_cnt_n = '0;
                    bit_idx_n  = '0;
                    state_n    = DATA;
                end
            end
            DATA: begin
                if (baud_last) begin
                    baud_cnt_n = '0;
                    shift_n    = {1'b0, shift[7:1]};
                    bit_idx_n  = bit_idx + 1'b1;
                    if (bit_idx == 3'd7) begin
                        state_n = STOP;
                    end
                end
            end
            STOP: begin
                if (baud_last) begin
                    baud_cnt_n = '0;
                    if (has_data) begin
                        pop     = 1'b1;
                        state_n = START;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
        endcase
        if (pop) begin
            shift_n = mem[rd_ptr];
        end
    end

    // Line level for the coming cycle, decoded from the next state
    always_comb begin
        tx_n = 1'b1;
        unique case (state_n)
            START:   tx_n = 1'b0;
            DATA:    tx_n = shift_n[0];
            default: tx_n = 1'b1;
        endcase
    end

    // FSM registers; tx is registered so it only moves on bit boundaries
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            tx       <= 1'b1;
        end else begin
            state    <= state_n;
            baud_cnt <= baud_cnt_n;
            bit_idx  <= bit_idx_n;
            shift    <= shift_n;
            tx       <= tx_n;
        end
    end

endmodule

// File: doc/mfp_uart_transmitter.md
Name: mfp_uart_transmitter

Overview:
Serial UART transmitter, the send-side counterpart of mfp_uart_receiver, for host-visible output (loader status, echo, debug dumps) on the board UART TX pin. It accepts bytes over a valid/ready handshake into an internal FIFO. Each byte is serialised as an 8N1 frame (start bit, 8 data bits LSB first, 1 stop bit). A memory-mapped AHB slave or the SREC loader status path feeds it.

Parameters:
CLOCK_FREQUENCY, 50000000, clock frequency in Hz
BAUD_RATE, 115200, serial bit rate
FIFO_DEPTH_LOG2, 4, log2 of FIFO depth in bytes (default 16 entries)

Ports:
clock  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
byte_data  input  8  byte to transmit
byte_valid  input  1  byte_data valid this cycle
byte_ready  output  1  FIFO can accept; transfer occurs on an edge where byte_valid && byte_ready
tx  output  1  serial line, idle high, registered
busy  output  1  high while a frame is on the line or the FIFO is non-empty
fifo_count  output  FIFO_DEPTH_LOG2+1  bytes currently queued (excludes the byte being shifted)

Behaviour:
- One clock; reset is synchronous and active-high. Ports are named clock and reset.
- CLKS_PER_BIT = CLOCK_FREQUENCY / BAUD_RATE (integer division). Values below 2 are illegal; guard with an elaboration-time check.
- Reset values: tx=1, busy=0, fifo_count=0, state=IDLE, bit counters=0. byte_ready=0 while reset is high and 1 on the first cycle after reset.
- FIFO:
  - Circular buffer with read/write pointers that wrap at 2^FIFO_DEPTH_LOG2.
  - byte_ready = (fifo_count != DEPTH), registered or derived from count only. No combinational path from the pop.
  - A push in the same cycle as a pop when full is not accepted, because byte_ready is already low.
  - Simultaneous push and pop when not full: count unchanged, both take effect.
  - byte_valid while byte_ready=0 is ignored; data is not lost because the sender holds it.
- FSM states:
  - IDLE: tx=1. If fifo_count!=0, pop the head into a shift register, go to START, clear the baud counter.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit_index=0.
  - DATA: tx=shift[0] for CLKS_PER_BIT cycles, then shift right and increment bit_index. After bit_index=7 completes, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. At the end, if fifo_count!=0, pop and go directly to START (no idle gap); else go to IDLE.
- Frame length is exactly 10*CLKS_PER_BIT cycles. tx is registered and glitch-free; it changes only on baud-counter boundaries.
- Latency: for a byte accepted at edge N into an empty FIFO with the FSM in IDLE:
  - fifo_count=1 after edge N.
  - Pop at edge N+1; tx falls after edge N+1; fifo_count returns to 0.
- busy = (state!=IDLE) || (fifo_count!=0).
- Reset mid-frame: on the next edge tx=1, FSM is IDLE, FIFO is flushed (count 0, pointers 0), and the partial frame is abandoned.

Test Plan:
Use CLOCK_FREQUENCY=800, BAUD_RATE=100, FIFO_DEPTH_LOG2=4, so CLKS_PER_BIT=8.
- Single byte 0xA5 pushed after reset -> tx low 8 cycles starting 1 cycle after acceptance, then bits 1,0,1,0,0,1,0,1 each 8 cycles, then stop high 8 cycles. busy high for exactly 81 cycles from acceptance, then 0.
- Bytes 0x00 then 0xFF pushed on consecutive cycles -> two frames totalling 160 cycles with no idle cycle between stop bit and second start bit. Receiver model decodes 0x00, 0xFF.
- Push 20 bytes 0x01..0x14 with byte_valid held high -> byte_ready drops when fifo_count=16 and re-rises one cycle after each pop. All 20 bytes are decoded in order; fifo_count never exceeds 16.
- FIFO full with byte_valid=1 in the cycle of a STOP->START pop -> byte not accepted that cycle; accepted the next cycle. fifo_count goes 16→15→16.
- Reset asserted at cycle 30 of a 0x3C frame -> tx=1 and fifo_count=0 on the next edge, busy=0. A subsequent 0x3C push transmits a clean 80-cycle frame.
- 0x55 frame -> tx transitions exactly every 8 cycles across start, data and stop (10 alternating bit periods). Checks CLKS_PER_BIT timing and LSB-first order.
